// File: rtl/hazard_stall_ctrl.sv
// Hazard/stall controller between ID decode and the ID/EX register: load-use bubbles,
// multi-cycle stall sequencing, redirect flush and external freeze in one small FSM.
module hazard_stall_ctrl #(
    parameter int                CTRL_W       = 10,
    parameter int                RA_W         = 5,
    parameter logic [CTRL_W-1:0] BUBBLE_MASK  = {CTRL_W{1'b1}},
    parameter int                LOAD_LAT     = 1,
    parameter int                FLUSH_CYCLES = 1,
    parameter int                CNT_W        = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CTRL_W-1:0] ctrl_in,
    input  logic [RA_W-1:0]   id_rs,
    input  logic [RA_W-1:0]   id_rt,
    input  logic              id_uses_rt,
    input  logic              ex_mem_read,
    input  logic [RA_W-1:0]   ex_rd,
    input  logic              redirect,
    input  logic              ext_stall,
    output logic [CTRL_W-1:0] ctrl_out,
    output logic              pc_write,
    output logic              ifid_write,
    output logic              ifid_flush,
    output logic              idex_bubble,
    output logic              pipe_hold,
    output logic              busy,
    output logic [CNT_W-1:0]  stall_cycles
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t             state_reg;
    logic [3:0]         cnt_reg;
    logic [CNT_W-1:0]   stall_cycles_reg;
    logic               hz;
    logic               flush_now;
    logic               bubble_now;

    // Register 0 is hardwired, so a load targeting it can never create a hazard.
    assign hz = ex_mem_read && (ex_rd != '0) &&
                ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));

    assign flush_now  = redirect || (state_reg == FLUSH);
    assign bubble_now = (state_reg == STALL) || hz;

    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        pipe_hold   = 1'b0;
        busy        = (state_reg != IDLE);
        if (!rst_n) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
            busy        = 1'b0;
        end else if (ext_stall) begin
            pipe_hold  = 1'b1;
            pc_write   = 1'b0;
            ifid_write = 1'b0;
        end else if (flush_now) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (bubble_now) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < CTRL_W; gi++) begin : g_mask
            assign ctrl_out[gi] = (idex_bubble && BUBBLE_MASK[gi]) ? 1'b0 : ctrl_in[gi];
        end
    endgenerate

    assign stall_cycles = stall_cycles_reg;

    // While ext_stall is high nothing advances; a pending redirect waits in EX.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg        <= IDLE;
            cnt_reg          <= 4'd0;
            stall_cycles_reg <= '0;
        end else if (!ext_stall) begin
            if (redirect) begin
                if (FLUSH_CYCLES > 1) begin
                    state_reg <= FLUSH;
                    cnt_reg   <= 4'(FLUSH_CYCLES - 1);
                end else begin
                    state_reg <= IDLE;
                    cnt_reg   <= 4'd0;
                end
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (hz) begin
                            if (!(&stall_cycles_reg))
                                stall_cycles_reg <= stall_cycles_reg + CNT_W'(1);
                            if (LOAD_LAT > 1) begin
                                state_reg <= STALL;
                                cnt_reg   <= 4'(LOAD_LAT - 1);
                            end
                        end
                    end
                    STALL: begin
                        if (!(&stall_cycles_reg))
                            stall_cycles_reg <= stall_cycles_reg + CNT_W'(1);
                        cnt_reg <= cnt_reg - 4'd1;
                        if (cnt_reg == 4'd1)
                            state_reg <= IDLE;
                    end
                    FLUSH: begin
                        cnt_reg <= cnt_reg - 4'd1;
                        if (cnt_reg == 4'd1)
                            state_reg <= IDLE;
                    end
                    default: begin
                        state_reg <= IDLE;
                        cnt_reg   <= 4'd0;
                    end
                endcase
            end
        end
    end

endmodule
